// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared pipeline hold codes and sequencer state encoding.
package pipe_hold_ctrl_pkg;

  localparam int unsigned BUS_HOLD_CODE_W = 3;
  localparam int unsigned WAIT_CNT_W      = 8;

  typedef logic [BUS_HOLD_CODE_W-1:0] hold_code_t;

  localparam hold_code_t HOLD_CODE_NONE = 3'd0;
  localparam hold_code_t HOLD_CODE_PC   = 3'd1;
  localparam hold_code_t HOLD_CODE_IF   = 3'd2;
  localparam hold_code_t HOLD_CODE_ID   = 3'd3;
  localparam hold_code_t HOLD_CODE_EX   = 3'd4;
  localparam hold_code_t HOLD_CODE_MEM  = 3'd5;

  typedef enum logic [1:0] {
    PHC_RUN  = 2'd0,
    PHC_LU   = 2'd1,
    PHC_DBW  = 2'd2,
    PHC_TRAP = 2'd3
  } phc_state_e;

endpackage

// File: rtl/pipe_wait_timer.sv
// Data-bus wait counter. start_i loads 1 for the first wait cycle, inc_i
// counts further wait cycles, clr_i returns to idle. timeout_o flags the
// cycle that would be the TIMEOUT-th consecutive wait cycle.
module pipe_wait_timer
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = WAIT_CNT_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central pipeline sequencer: hold code, bubble/flush strobes, PC redirect.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int unsigned DBUS_TIMEOUT = 16,
  parameter int unsigned ADDR_W       = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_bypass_i,
  input  logic              jmp_taken_i,
  input  logic [ADDR_W-1:0] jmp_addr_i,
  input  logic              ibus_ready_i,
  input  logic              dbus_req_i,
  input  logic              dbus_ready_i,
  input  logic              except_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  output logic [2:0]        hold_code_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic              bus_err_o
);

  phc_state_e state_q;
  phc_state_e state_d;

  logic tmr_start;
  logic tmr_inc;
  logic tmr_clr;
  logic tmr_timeout;
  logic dbus_wait;

  assign dbus_wait = dbus_req_i && !dbus_ready_i;

  pipe_wait_timer #(
    .TIMEOUT (DBUS_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (tmr_start),
    .inc_i     (tmr_inc),
    .clr_i     (tmr_clr),
    .timeout_o (tmr_timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PHC_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // RUN and LU_STALL share the priority chain; LU_STALL only drops load-use.
  always_comb begin
    state_d         = state_q;
    hold_code_o     = HOLD_CODE_NONE;
    flush_ifid_o    = 1'b0;
    flush_idex_o    = 1'b0;
    redirect_o      = 1'b0;
    redirect_addr_o = '0;
    bus_err_o       = 1'b0;
    tmr_start       = 1'b0;
    tmr_inc         = 1'b0;
    tmr_clr         = 1'b0;

    if (!rst_n) begin
      state_d = PHC_RUN;
    end else begin
      unique case (state_q)
        PHC_RUN, PHC_LU: begin
          state_d = PHC_RUN;
          if (except_i) begin
            redirect_o      = 1'b1;
            redirect_addr_o = trap_vec_i;
            flush_ifid_o    = 1'b1;
            flush_idex_o    = 1'b1;
            state_d         = PHC_TRAP;
          end else if (dbus_wait) begin
            hold_code_o = HOLD_CODE_MEM;
            tmr_start   = 1'b1;
            state_d     = PHC_DBW;
          end else if (load_bypass_i && (state_q == PHC_RUN)) begin
            hold_code_o  = HOLD_CODE_ID;
            flush_idex_o = 1'b1;
            state_d      = PHC_LU;
          end else if (jmp_taken_i) begin
            redirect_o      = 1'b1;
            redirect_addr_o = jmp_addr_i;
            flush_ifid_o    = 1'b1;
          end else if (!ibus_ready_i) begin
            hold_code_o  = HOLD_CODE_IF;
            flush_ifid_o = 1'b1;
          end
        end
        PHC_DBW: begin
          if (dbus_ready_i) begin
            tmr_clr = 1'b1;
            state_d = PHC_RUN;
          end else if (tmr_timeout) begin
            bus_err_o       = 1'b1;
            redirect_o      = 1'b1;
            redirect_addr_o = trap_vec_i;
            flush_ifid_o    = 1'b1;
            flush_idex_o    = 1'b1;
            tmr_clr         = 1'b1;
            state_d         = PHC_TRAP;
          end else begin
            hold_code_o = HOLD_CODE_MEM;
            tmr_inc     = 1'b1;
          end
        end
        PHC_TRAP: begin
          flush_ifid_o = 1'b1;
          state_d      = PHC_RUN;
        end
        default: begin
          state_d = PHC_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
module tb_pipe_hold_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned AW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_bypass;
  logic          jmp_taken;
  logic [AW-1:0] jmp_addr;
  logic          ibus_ready;
  logic          dbus_req;
  logic          dbus_ready;
  logic          except_in;
  logic [AW-1:0] trap_vec;
  logic [2:0]    hold_code;
  logic          flush_ifid;
  logic          flush_idex;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          bus_err;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(
    .DBUS_TIMEOUT (TO),
    .ADDR_W       (AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_bypass_i   (load_bypass),
    .jmp_taken_i     (jmp_taken),
    .jmp_addr_i      (jmp_addr),
    .ibus_ready_i    (ibus_ready),
    .dbus_req_i      (dbus_req),
    .dbus_ready_i    (dbus_ready),
    .except_i        (except_in),
    .trap_vec_i      (trap_vec),
    .hold_code_o     (hold_code),
    .flush_ifid_o    (flush_ifid),
    .flush_idex_o    (flush_idex),
    .redirect_o      (redirect),
    .redirect_addr_o (redirect_addr),
    .bus_err_o       (bus_err)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference history: previous cycle was a trap entry / a load-use bubble,
  // and how many consecutive data-bus wait cycles have elapsed.
  bit          m_trap, m_lu;
  int unsigned m_wait;
  bit          n_trap, n_lu;
  int unsigned n_wait;

  logic [2:0]    e_hold, o_hold;
  logic          e_fi, e_fe, e_rd, e_be, o_fi, o_fe, o_rd, o_be;
  logic [AW-1:0] e_addr, o_addr;

  function automatic void model_eval();
    e_hold = 3'd0; e_fi = 1'b0; e_fe = 1'b0; e_rd = 1'b0; e_be = 1'b0; e_addr = '0;
    n_trap = 1'b0; n_lu = 1'b0; n_wait = 0;
    if (!rst_n) return;
    if (m_trap) begin
      e_fi = 1'b1;
    end else if (m_wait > 0) begin
      if (dbus_ready) begin
        e_hold = 3'd0;
      end else if (m_wait + 1 == TO) begin
        e_be = 1'b1; e_rd = 1'b1; e_addr = trap_vec; e_fi = 1'b1; e_fe = 1'b1;
        n_trap = 1'b1;
      end else begin
        e_hold = 3'd5;
        n_wait = m_wait + 1;
      end
    end else if (except_in) begin
      e_rd = 1'b1; e_addr = trap_vec; e_fi = 1'b1; e_fe = 1'b1;
      n_trap = 1'b1;
    end else if (dbus_req && !dbus_ready) begin
      e_hold = 3'd5;
      n_wait = 1;
    end else if (load_bypass && !m_lu) begin
      e_hold = 3'd3; e_fe = 1'b1;
      n_lu = 1'b1;
    end else if (jmp_taken) begin
      e_rd = 1'b1; e_addr = jmp_addr; e_fi = 1'b1;
    end else if (!ibus_ready) begin
      e_hold = 3'd2; e_fi = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    o_hold = hold_code; o_fi = flush_ifid; o_fe = flush_idex;
    o_rd = redirect; o_addr = redirect_addr; o_be = bus_err;
    chk("hold_code", 64'(o_hold), 64'(e_hold));
    chk("flush_ifid", 64'(o_fi), 64'(e_fi));
    chk("flush_idex", 64'(o_fe), 64'(e_fe));
    chk("redirect", 64'(o_rd), 64'(e_rd));
    chk("redirect_addr", o_addr, e_addr);
    chk("bus_err", 64'(o_be), 64'(e_be));
    @(posedge clk);
    m_trap = n_trap; m_lu = n_lu; m_wait = n_wait;
    #1;
  endtask

  int unsigned stuck;

  initial begin
    rst_n = 1'b0; load_bypass = 1'b0; jmp_taken = 1'b0; jmp_addr = '0;
    ibus_ready = 1'b0; dbus_req = 1'b0; dbus_ready = 1'b0; except_in = 1'b0;
    trap_vec = '0;
    m_trap = 1'b0; m_lu = 1'b0; m_wait = 0;
    stuck = 0;

    // reset, then idle run
    repeat (2) cycle();
    chk("reset_hold", 64'(o_hold), 64'd0);
    rst_n = 1'b1; ibus_ready = 1'b1;
    repeat (10) cycle();
    chk("idle_redirect", 64'(o_rd), 64'd0);

    // load-use bubble then LU_STALL
    load_bypass = 1'b1;
    cycle();
    chk("lu_hold", 64'(o_hold), 64'd3);
    chk("lu_flush_idex", 64'(o_fe), 64'd1);
    cycle();
    chk("lus_hold", 64'(o_hold), 64'd0);
    chk("lus_flush_idex", 64'(o_fe), 64'd0);
    load_bypass = 1'b0;

    // dbus wait with a deferred jump
    dbus_req = 1'b1; dbus_ready = 1'b0;
    jmp_taken = 1'b1; jmp_addr = 64'h8000_0040;
    repeat (3) begin
      cycle();
      chk("dbw_hold", 64'(o_hold), 64'd5);
      chk("dbw_no_redirect", 64'(o_rd), 64'd0);
    end
    dbus_ready = 1'b1;
    cycle();
    chk("dbw_ready_hold", 64'(o_hold), 64'd0);
    chk("dbw_ready_no_redirect", 64'(o_rd), 64'd0);
    dbus_req = 1'b0; dbus_ready = 1'b0;
    cycle();
    chk("deferred_redirect", 64'(o_rd), 64'd1);
    chk("deferred_addr", o_addr, 64'h8000_0040);
    jmp_taken = 1'b0;
    cycle();

    // dbus timeout
    trap_vec = 64'h100; dbus_req = 1'b1; dbus_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("to_hold", 64'(o_hold), 64'd5);
    end
    cycle();
    chk("to_bus_err", 64'(o_be), 64'd1);
    chk("to_addr", o_addr, 64'h100);
    chk("to_flush_idex", 64'(o_fe), 64'd1);
    dbus_req = 1'b0;
    cycle();
    chk("to_trap_flush", 64'(o_fi), 64'd1);
    chk("to_trap_bus_err", 64'(o_be), 64'd0);
    cycle();
    chk("to_run_flush", 64'(o_fi), 64'd0);

    // exception beats load-use and jump; repeat ignored in TRAP
    trap_vec = 64'h0000_0000_0000_0200;
    except_in = 1'b1; load_bypass = 1'b1; jmp_taken = 1'b1; jmp_addr = 64'h40;
    cycle();
    chk("exc_addr", o_addr, 64'h200);
    chk("exc_flush_idex", 64'(o_fe), 64'd1);
    cycle();
    chk("exc_repeat_redirect", 64'(o_rd), 64'd0);
    chk("exc_repeat_flush", 64'(o_fi), 64'd1);
    except_in = 1'b0; load_bypass = 1'b0; jmp_taken = 1'b0;
    cycle();

    // reset during DBUS_WAIT, counter restarts
    dbus_req = 1'b1; dbus_ready = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_hold", 64'(o_hold), 64'd0);
    rst_n = 1'b1; dbus_req = 1'b0;
    cycle();
    chk("rst_after_hold", 64'(o_hold), 64'd0);
    chk("rst_after_bus_err", 64'(o_be), 64'd0);
    dbus_req = 1'b1;
    repeat (3) cycle();
    chk("restart_hold", 64'(o_hold), 64'd5);
    cycle();
    chk("restart_bus_err", 64'(o_be), 64'd1);
    dbus_req = 1'b0;
    repeat (2) cycle();

    // randomized traffic against the reference model
    repeat (600) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      except_in   = ($urandom_range(0, 19) == 0);
      load_bypass = ($urandom_range(0, 3) == 0);
      jmp_taken   = ($urandom_range(0, 3) == 0);
      jmp_addr    = {$urandom, $urandom};
      trap_vec    = {$urandom, $urandom};
      ibus_ready  = ($urandom_range(0, 4) != 0);
      if (stuck == 0 && $urandom_range(0, 24) == 0) stuck = $urandom_range(2, 6);
      if (stuck > 0) begin
        dbus_req = 1'b1; dbus_ready = 1'b0; stuck--;
      end else begin
        dbus_req   = ($urandom_range(0, 2) == 0);
        dbus_ready = ($urandom_range(0, 2) != 0);
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
